// File: rtl/uart_host_rx.sv
// uart_host_rx: host-side 8N1 serial receiver with a first-word-fall-through
// byte FIFO.
//
// Ports:
//   clk       - single clock, all logic on the rising edge
//   reset     - asynchronous active-low reset (0 = reset)
//   rx        - asynchronous serial input, idles high
//   rd_data   - byte at the FIFO head (0 while empty)
//   rd_valid  - FIFO not empty
//   rd_ready  - consumer pop; a pop occurs on rd_valid && rd_ready
//   count     - FIFO occupancy, 0..2**FIFO_AW
//   frame_err - one-cycle pulse when a stop bit is sampled low
//   overflow  - one-cycle pulse when a good byte is dropped on a full FIFO
module uart_host_rx #(
    parameter int BOARD_CK = 32000000,
    parameter int BAUD     = 115200,
    parameter int FIFO_AW  = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               rx,
    output logic [7:0]         rd_data,
    output logic               rd_valid,
    input  logic               rd_ready,
    output logic [FIFO_AW:0]   count,
    output logic               frame_err,
    output logic               overflow
);

    localparam int BIT   = (BOARD_CK + BAUD / 2) / BAUD;
    localparam int HALF  = BIT / 2;
    localparam int CW    = $clog2(BIT) + 1;
    localparam int DEPTH = 2 ** FIFO_AW;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [2:0]      idx, idx_n;
    logic [7:0]      sh, sh_n;
    logic            sync1, rxs;
    logic            push, ferr_n, ovf_n;
    logic            pop, wr_en;

    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;

    // ---------------- receive FSM ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1     <= 1'b1;
            rxs       <= 1'b1;
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            sh        <= '0;
            frame_err <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            sync1     <= rx;
            rxs       <= sync1;
            state     <= state_n;
            cnt       <= cnt_n;
            idx       <= idx_n;
            sh        <= sh_n;
            frame_err <= ferr_n;
            overflow  <= ovf_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        sh_n    = sh;
        push    = 1'b0;
        ferr_n  = 1'b0;
        case (state)
            IDLE: begin
                if (!rxs) begin
                    state_n = START;
                    cnt_n   = CW'(HALF - 1);
                end
            end
            START: begin
                if (cnt == '0) begin
                    // Start bit must still be low at its centre, else glitch.
                    if (!rxs) begin
                        state_n = DATA;
                        cnt_n   = CW'(BIT - 1);
                        idx_n   = '0;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            DATA: begin
                if (cnt == '0) begin
                    // LSB-first: after 8 right shifts bit 0 holds the first bit.
                    sh_n  = {rxs, sh[7:1]};
                    cnt_n = CW'(BIT - 1);
                    idx_n = idx + 1'b1;
                    if (idx == 3'd7) state_n = STOP;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            STOP: begin
                if (cnt == '0) begin
                    if (rxs) begin
                        push    = 1'b1;
                        state_n = IDLE;
                    end else begin
                        ferr_n  = 1'b1;
                        state_n = BREAK;
                    end
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            BREAK: begin
                // Hold off until the line returns high so a stuck-low line
                // does not generate a stream of bogus frames.
                if (rxs) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // ---------------- FWFT FIFO ----------------
    assign rd_valid = (count != '0);
    assign rd_data  = rd_valid ? mem[rd_ptr] : 8'h00;
    assign pop      = rd_valid && rd_ready;
    // A full FIFO still accepts a push when a pop frees the head this cycle.
    assign wr_en    = push && ((count != (FIFO_AW + 1)'(DEPTH)) || pop);
    assign ovf_n    = push && !wr_en;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= sh_n;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_host_rx.sv
module tb_uart_host_rx;

    localparam int BOARD_CK = 1600000;
    localparam int BAUD     = 100000;
    localparam int FIFO_AW  = 4;
    localparam int BIT      = 16;
    localparam int DEPTH    = 16;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             rx = 1'b1;
    logic             rd_ready = 1'b0;
    logic [7:0]       rd_data;
    logic             rd_valid;
    logic [FIFO_AW:0] count;
    logic             frame_err;
    logic             overflow;

    uart_host_rx #(.BOARD_CK(BOARD_CK), .BAUD(BAUD), .FIFO_AW(FIFO_AW)) dut (
        .clk(clk), .reset(reset), .rx(rx), .rd_data(rd_data), .rd_valid(rd_valid),
        .rd_ready(rd_ready), .count(count), .frame_err(frame_err), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int n_ferr = 0;
    int n_ovf = 0;
    int last_rise = -1;
    logic prev_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (frame_err) n_ferr <= n_ferr + 1;
        if (overflow)  n_ovf  <= n_ovf + 1;
        if (rd_valid && !prev_valid) last_rise <= cyc;
        prev_valid <= rd_valid;
    end

    // reference model: byte queue plus expected pulse totals
    logic [7:0] q[$];
    int exp_ferr = 0;
    int exp_ovf  = 0;
    int t_start  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called just after a posedge; returns just after a posedge.
    // Line is left at the stop-bit value.
    task automatic send_byte(input logic [7:0] b, input logic stop, input bit pop_at_stop);
        t_start = cyc;
        rx = 1'b0;
        repeat (BIT) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT) @(posedge clk);
            #1;
        end
        rx = stop;
        if (pop_at_stop) begin
            // stop bit is sampled 11 cycles into the stop bit period
            repeat (10) @(posedge clk);
            #1 rd_ready = 1'b1;
            @(posedge clk);
            #1 rd_ready = 1'b0;
            repeat (BIT - 11) @(posedge clk);
            #1;
        end else begin
            repeat (BIT) @(posedge clk);
            #1;
        end
        // model the frame's outcome
        if (!stop) begin
            exp_ferr++;
        end else begin
            if (pop_at_stop && q.size() > 0) void'(q.pop_front());
            if (q.size() < DEPTH) q.push_back(b);
            else exp_ovf++;
        end
    endtask

    task automatic drain(input string tag);
        while (q.size() > 0) begin
            @(negedge clk);
            chk({tag, "_valid"}, 32'(rd_valid), 32'd1);
            chk({tag, "_data"}, 32'(rd_data), 32'(q[0]));
            chk({tag, "_count"}, 32'(count), 32'(q.size()));
            rd_ready = 1'b1;
            @(posedge clk);
            #1 rd_ready = 1'b0;
            void'(q.pop_front());
        end
        @(negedge clk);
        chk({tag, "_empty_valid"}, 32'(rd_valid), 32'd0);
        chk({tag, "_empty_count"}, 32'(count), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_pulses(input string tag);
        @(negedge clk);
        chk({tag, "_ferr_total"}, 32'(n_ferr), 32'(exp_ferr));
        chk({tag, "_ovf_total"}, 32'(n_ovf), 32'(exp_ovf));
        chk({tag, "_count"}, 32'(count), 32'(q.size()));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int base;
        logic [7:0] b;

        // ---- reset and idle ----
        reset = 1'b0;
        rx = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("rst_valid", 32'(rd_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_data", 32'(rd_data), 32'd0);
        chk("rst_ferr", 32'(frame_err), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        reset = 1'b1;
        repeat (500) @(posedge clk);
        #1;
        chk("idle_valid", 32'(rd_valid), 32'd0);
        chk_pulses("idle");

        // pop on empty is ignored
        rd_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rd_ready = 1'b0;
        chk("empty_pop_count", 32'(count), 32'd0);

        // ---- single byte, with latency ----
        send_byte(8'hA5, 1'b1, 1'b0);
        chk("single_rise_cycle", 32'(last_rise), 32'(t_start + 155));
        chk("single_data", 32'(rd_data), 32'hA5);
        chk("single_count", 32'(count), 32'd1);
        rd_ready = 1'b1;
        @(posedge clk);
        #1 rd_ready = 1'b0;
        void'(q.pop_front());
        chk("single_pop_count", 32'(count), 32'd0);

        // ---- burst overfilling the FIFO ----
        base = n_ovf;
        for (int i = 0; i < 18; i++) send_byte(8'(i), 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("burst_count", 32'(count), 32'd16);
        chk("burst_ovf_two", 32'(n_ovf - base), 32'd2);
        chk_pulses("burst");
        drain("burst_drain");

        // ---- simultaneous push and pop at full ----
        for (int i = 0; i < DEPTH; i++) send_byte(8'($urandom_range(0, 255)), 1'b1, 1'b0);
        chk("full_count", 32'(count), 32'd16);
        base = n_ovf;
        send_byte(8'h5A, 1'b1, 1'b1);
        chk("pushpop_count", 32'(count), 32'd16);
        chk("pushpop_no_ovf", 32'(n_ovf - base), 32'd0);
        chk("pushpop_tail", 32'(q[q.size()-1]), 32'h5A);
        drain("pushpop_drain");

        // ---- framing error and held-low break ----
        base = n_ferr;
        send_byte(8'h3C, 1'b0, 1'b0);
        repeat (100 * BIT) @(posedge clk);
        #1;
        chk("break_ferr_once", 32'(n_ferr - base), 32'd1);
        chk("break_no_push", 32'(count), 32'd0);
        rx = 1'b1;
        repeat (3 * BIT) @(posedge clk);
        #1;
        send_byte(8'h7E, 1'b1, 1'b0);
        chk("after_break_data", 32'(rd_data), 32'h7E);
        chk_pulses("after_break");
        drain("after_break_drain");

        // ---- glitch ----
        rx = 1'b0;
        repeat (4) @(posedge clk);
        #1 rx = 1'b1;
        repeat (12 * BIT) @(posedge clk);
        #1;
        chk("glitch_valid", 32'(rd_valid), 32'd0);
        chk_pulses("glitch");

        // ---- randomized bytes with random idle gaps ----
        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom_range(0, 255));
            send_byte(b, 1'b1, 1'b0);
            repeat ($urandom_range(0, 40)) @(posedge clk);
            #1;
        end
        chk_pulses("rand");
        drain("rand_drain");

        // ---- mid-frame reset ----
        send_byte(8'($urandom_range(0, 255)), 1'b1, 1'b0);
        chk("pre_reset_count", 32'(count), 32'd1);
        rx = 1'b0;
        repeat (BIT) @(posedge clk);
        #1 rx = 1'b1;
        repeat (3 * BIT + 8) @(posedge clk);   // middle of data bit 3 of 0xFF
        #1 reset = 1'b0;
        #1;
        chk("midrst_count", 32'(count), 32'd0);
        chk("midrst_valid", 32'(rd_valid), 32'd0);
        chk("midrst_data", 32'(rd_data), 32'd0);
        q.delete();
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (2 * BIT) @(posedge clk);
        #1;
        chk("post_rst_idle_count", 32'(count), 32'd0);
        send_byte(8'h81, 1'b1, 1'b0);
        chk("post_rst_data", 32'(rd_data), 32'h81);
        chk_pulses("post_rst");
        drain("post_rst_drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
